// File: rtl/uart_tx_feeder_if.sv
// Byte-write and transmitter-facing signals of uart_tx_feeder, bundled so user
// logic and the feeder share one port list.
interface uart_tx_feeder_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic          tx_busy;
    logic [7:0]    uart_tx_data;
    logic          uart_tx_en;

    modport master (
        output wr_data, wr_en,
        input  full, empty, fifo_cnt, overflow, tx_busy, uart_tx_data, uart_tx_en
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, fifo_cnt, overflow, tx_busy, uart_tx_data, uart_tx_en
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// FIFO plus pacing controller ahead of a busy-less UART transmitter: pops one
// byte per frame and spaces uart_tx_en rises FRAME_CNT cycles apart.
module uart_tx_feeder #(
    parameter int BPS        = 'd9_600,
    parameter int CLK_FRE    = 'd50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int EN_HIGH    = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    uart_tx_feeder_if.slave      bus
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int BPS_CNT   = CLK_FRE / BPS;
    localparam int FRAME_CNT = 10 * BPS_CNT + EN_HIGH;

    localparam logic [23:0]   EN_HIGH_C  = 24'(EN_HIGH);
    localparam logic [23:0]   FRAME_LAST = 24'(FRAME_CNT - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    generate
        if (FRAME_CNT >= (1 << 24)) begin : g_bad_frame
            $error("uart_tx_feeder: FRAME_CNT does not fit the 24-bit pace counter");
        end
        if (EN_HIGH < 3) begin : g_bad_en_high
            $error("uart_tx_feeder: EN_HIGH must be at least 3");
        end
        if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_feeder: FIFO_DEPTH must be a power of two in 2..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t        r_state;
    logic [23:0]   r_pace;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    logic          r_tx_en;

    logic          w_wr_acc;
    logic          w_pop;
    logic [CW-1:0] w_cnt_next;

    // Acceptance uses the registered full flag, so a pop in the same cycle
    // does not make room for a write.
    assign w_wr_acc = bus.wr_en & ~r_full;
    assign w_pop    = (r_state == ST_IDLE) & ~r_empty;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr_acc && !w_pop) begin
            w_cnt_next = r_cnt + CW'(1);
        end else if (!w_wr_acc && w_pop) begin
            w_cnt_next = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_cnt      <= w_cnt_next;
            r_full     <= (w_cnt_next == DEPTH_C);
            r_empty    <= (w_cnt_next == '0);
            r_overflow <= bus.wr_en & r_full;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_pace    <= '0;
            r_rd_ptr  <= '0;
            r_tx_data <= 8'd0;
            r_tx_en   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_en <= 1'b0;
                    if (!r_empty) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_rd_ptr  <= r_rd_ptr + AW'(1);
                        r_tx_en   <= 1'b1;
                        r_pace    <= 24'd1;
                        r_state   <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    r_pace <= r_pace + 24'd1;
                    if (r_pace == EN_HIGH_C) begin
                        r_tx_en <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Leaving one cycle early lets IDLE's pop land exactly FRAME_CNT after the last rise.
                    r_pace <= r_pace + 24'd1;
                    if (r_pace == FRAME_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.fifo_cnt     = r_cnt;
    assign bus.overflow     = r_overflow;
    assign bus.tx_busy      = ~r_empty | (r_state != ST_IDLE);
    assign bus.uart_tx_data = r_tx_data;
    assign bus.uart_tx_en   = r_tx_en;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized self-checking bench for uart_tx_feeder against a timestamp-based
// queue model of the FIFO and frame pacing.
module tb_uart_tx_feeder;
    localparam int CLK_FRE    = 1000;
    localparam int BPS        = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int EN_HIGH    = 4;
    localparam int FRAME      = 10 * (CLK_FRE / BPS) + EN_HIGH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_feeder_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_tx_feeder #(
        .BPS       (BPS),
        .CLK_FRE   (CLK_FRE),
        .FIFO_DEPTH(FIFO_DEPTH),
        .EN_HIGH   (EN_HIGH)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes queue, edge counter, and the edge of the last en rise.
    logic [7:0] m_q[$];
    int         cyc = 0;
    int         last_rise = -100000;
    logic [7:0] m_data = 8'd0;
    logic       m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            cyc       = 0;
            last_rise = -100000;
            m_data    = 8'd0;
            m_ovf     = 1'b0;
        end else begin
            int sz;
            sz    = m_q.size();
            cyc   = cyc + 1;
            m_ovf = bus.wr_en && (sz == FIFO_DEPTH);
            if (sz > 0 && (cyc - last_rise) >= FRAME) begin
                m_data    = m_q.pop_front();
                last_rise = cyc;
            end
            if (bus.wr_en && sz < FIFO_DEPTH) m_q.push_back(bus.wr_data);
        end
    end

    // Monitor of DUT enable rises.
    int         d_rise_cyc[$];
    logic [7:0] d_rise_byte[$];
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (bus.uart_tx_en && !prev_en) begin
            d_rise_cyc.push_back(cyc);
            d_rise_byte.push_back(bus.uart_tx_data);
        end
        prev_en = bus.uart_tx_en;
    end

    function automatic logic [15:0] act_vec();
        return {bus.uart_tx_en, bus.uart_tx_data, bus.fifo_cnt, bus.full,
                bus.empty, bus.overflow, bus.tx_busy};
    endfunction

    function automatic logic [15:0] exp_vec();
        int   sz   = m_q.size();
        logic en   = (cyc - last_rise) < EN_HIGH;
        logic busy = (sz != 0) || ((cyc - last_rise) < FRAME - 1);
        return {en, m_data, 3'(sz), sz == FIFO_DEPTH, sz == 0, m_ovf, busy};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (act_vec() !== 16'h0004) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", act_vec(), 16'h0004);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int en_hi = 0;
        int r0 = d_rise_cyc.size();
        int wr_edge;
        int fall_cyc = -1;
        bus.wr_data = 8'hA5;
        bus.wr_en = 1'b1;
        @(negedge clk);
        wr_edge = cyc;
        bus.wr_en = 1'b0;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.uart_tx_en) en_hi++;
            if (!bus.tx_busy && fall_cyc < 0) fall_cyc = cyc;
        end
        checks++;
        if (en_hi != EN_HIGH) begin
            errors++;
            $display("FAIL single_en_width got=%0d exp=%0d", en_hi, EN_HIGH);
        end
        checks++;
        if (d_rise_cyc.size() != r0 + 1 || d_rise_byte[r0] !== 8'hA5 || d_rise_cyc[r0] != wr_edge + 1) begin
            errors++;
            $display("FAIL single_rise got_rises=%0d exp=1 (byte/latency wrong)", d_rise_cyc.size() - r0);
        end
        checks++;
        if (fall_cyc - wr_edge != FRAME) begin
            errors++;
            $display("FAIL single_busy_fall got=%0d exp=%0d", fall_cyc - wr_edge, FRAME);
        end
        $display("test_single done: byte a5 en_high=%0d", en_hi);
    endtask

    task automatic test_burst();
        logic [7:0] b[3];
        int r0 = d_rise_cyc.size();
        for (int k = 0; k < 3; k++) begin
            b[k] = 8'($urandom);
            bus.wr_data = b[k];
            bus.wr_en = 1'b1;
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst_wr cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 3 * FRAME + 20; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (d_rise_cyc.size() != r0 + 3) begin
            errors++;
            $display("FAIL burst_count got=%0d exp=3", d_rise_cyc.size() - r0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_rise_byte[r0 + k] !== b[k]) begin
                    errors++;
                    $display("FAIL burst_order k=%0d got=%h exp=%h", k, d_rise_byte[r0 + k], b[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (d_rise_cyc[r0 + k] - d_rise_cyc[r0 + k - 1] != FRAME) begin
                        errors++;
                        $display("FAIL burst_spacing k=%0d got=%0d exp=%0d", k,
                                 d_rise_cyc[r0 + k] - d_rise_cyc[r0 + k - 1], FRAME);
                    end
                end
            end
        end
        $display("test_burst done: %h %h %h", b[0], b[1], b[2]);
    endtask

    task automatic test_overflow();
        logic [7:0] b[6];
        int ovf_cnt = 0;
        int r0 = d_rise_cyc.size();
        for (int k = 0; k < 6; k++) begin
            b[k] = 8'($urandom);
            bus.wr_data = b[k];
            bus.wr_en = 1'b1;
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_wr cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.overflow) ovf_cnt++;
            if (k == 3 || k == 4) begin
                checks++;
                if (bus.full !== (k == 4)) begin
                    errors++;
                    $display("FAIL ovf_full_after_write%0d got=%b exp=%b", k + 1, bus.full, k == 4);
                end
            end
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 5 * FRAME + 20; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.overflow) ovf_cnt++;
        end
        checks++;
        if (ovf_cnt != 1) begin
            errors++;
            $display("FAIL ovf_pulses got=%0d exp=1", ovf_cnt);
        end
        checks++;
        if (d_rise_cyc.size() != r0 + 5) begin
            errors++;
            $display("FAIL ovf_tx_count got=%0d exp=5", d_rise_cyc.size() - r0);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (d_rise_byte[r0 + k] !== b[k]) begin
                    errors++;
                    $display("FAIL ovf_order k=%0d got=%h exp=%h", k, d_rise_byte[r0 + k], b[k]);
                end
            end
        end
        $display("test_overflow done: overflow pulses=%0d", ovf_cnt);
    endtask

    task automatic test_full_pop();
        int guard = 0;
        for (int k = 0; k < 5; k++) begin
            bus.wr_data = 8'($urandom);
            bus.wr_en = 1'b1;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        while ((cyc + 1 - last_rise) < FRAME && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fullpop_wait cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (guard >= 2 * FRAME || m_q.size() != FIFO_DEPTH) begin
            errors++;
            $display("FAIL fullpop_setup got_size=%0d exp=%0d", m_q.size(), FIFO_DEPTH);
        end
        bus.wr_data = 8'($urandom);
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_cnt !== 3'(FIFO_DEPTH - 1)) begin
            errors++;
            $display("FAIL fullpop_drop got_ovf=%b got_cnt=%0d exp_ovf=1 exp_cnt=%0d",
                     bus.overflow, bus.fifo_cnt, FIFO_DEPTH - 1);
        end
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fullpop_drain cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        $display("test_full_pop done");
    endtask

    task automatic test_reset_mid_gap();
        int r0;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data = 8'($urandom);
            bus.wr_en = 1'b1;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midgap_pre cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== 16'h0004) begin
            errors++;
            $display("FAIL midgap_async_reset got=%h exp=%h", act_vec(), 16'h0004);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = d_rise_cyc.size();
        repeat (3 * FRAME) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midgap_post cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (d_rise_cyc.size() != r0) begin
            errors++;
            $display("FAIL midgap_no_rise got=%0d exp=0", d_rise_cyc.size() - r0);
        end
        $display("test_reset_mid_gap done");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] b0 = 8'($urandom);
            logic [7:0] b1 = 8'($urandom);
            int r0 = d_rise_cyc.size();
            for (int i = 0; i < 2 * FRAME + 20; i++) begin
                bus.wr_en = (i == 0) || (i == 3);
                bus.wr_data = (i == 0) ? b0 : b1;
                @(negedge clk);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL b2b it=%0d cyc=%0d got=%h exp=%h", it, cyc, act_vec(), exp_vec());
                end
            end
            bus.wr_en = 1'b0;
            checks++;
            if (d_rise_cyc.size() != r0 + 2 || d_rise_byte[r0] !== b0 || d_rise_byte[r0 + 1] !== b1
                || d_rise_cyc[r0 + 1] - d_rise_cyc[r0] != FRAME) begin
                errors++;
                $display("FAIL b2b_pair it=%0d got_rises=%0d exp=2 exp_bytes=%h,%h spacing_exp=%0d",
                         it, d_rise_cyc.size() - r0, b0, b1, FRAME);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int r0 = d_rise_cyc.size();
        int guard = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.wr_en = ($urandom_range(0, 39) == 0) || (i % 300 < 7);
            bus.wr_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        bus.wr_en = 1'b0;
        while ((bus.tx_busy || exp_vec()[0]) && guard < 10 * FRAME) begin
            @(negedge clk);
            guard++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (guard >= 10 * FRAME) begin
            errors++;
            $display("FAIL random_drain_timeout got_busy=%b exp_busy=0", bus.tx_busy);
        end
        for (int k = r0 + 1; k < d_rise_cyc.size(); k++) begin
            checks++;
            if (d_rise_cyc[k] - d_rise_cyc[k - 1] < FRAME) begin
                errors++;
                $display("FAIL random_spacing got=%0d exp>=%0d", d_rise_cyc[k] - d_rise_cyc[k - 1], FRAME);
            end
        end
        $display("test_random done: %0d frames", d_rise_cyc.size() - r0);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = 8'd0;
        test_reset();
        repeat (5) @(negedge clk);
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid_gap();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
